// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared widths, default depth and FSM state encoding for the data-memory responder
package dmem_responder_pkg;

   localparam int DATA_WIDTH       = 32;
   localparam int RAM_ADDR_WIDTH   = 12;
   localparam int DMEM_DEPTH_WORDS = 1024;

   typedef enum logic [1:0] {
      DMEM_ST_IDLE    = 2'd0,
      DMEM_ST_RD_WAIT = 2'd1,
      DMEM_ST_RD_DONE = 2'd2
   } dmem_state_e;

   function automatic int idx_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - core-to-data-memory port bundle (d_w_*, d_r_*, stall)
// access_err is present only when DMEM_BOUNDS_CHECK_EN is defined.
interface dmem_responder_if #(
   parameter int DATA_WIDTH = dmem_responder_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH = dmem_responder_pkg::RAM_ADDR_WIDTH
);
   logic [ADDR_WIDTH-1:0]   w_addr;
   logic [DATA_WIDTH-1:0]   w_dat;
   logic                    w_enb;
   logic [DATA_WIDTH/8-1:0] w_byte_enb;
   logic [ADDR_WIDTH-1:0]   r_addr;
   logic                    r_enb;
   logic [DATA_WIDTH-1:0]   r_dat;
   logic                    r_valid;
   logic                    stall;
`ifdef DMEM_BOUNDS_CHECK_EN
   logic                    access_err;

   modport master (output w_addr, w_dat, w_enb, w_byte_enb, r_addr, r_enb,
                   input  r_dat, r_valid, stall, access_err);
   modport slave  (input  w_addr, w_dat, w_enb, w_byte_enb, r_addr, r_enb,
                   output r_dat, r_valid, stall, access_err);
`else
   modport master (output w_addr, w_dat, w_enb, w_byte_enb, r_addr, r_enb,
                   input  r_dat, r_valid, stall);
   modport slave  (input  w_addr, w_dat, w_enb, w_byte_enb, r_addr, r_enb,
                   output r_dat, r_valid, stall);
`endif
endinterface

// File: rtl/dmem_responder_array.sv
// rtl/dmem_responder_array.sv - dmem_array: byte-banked word store, byte-enabled write, registered read
// Read-first: a read and a write to the same word on one edge returns the old contents.
module dmem_array #(
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH_WORDS = 1024,
   parameter int IDX_W       = 10
) (
   input  logic                    clk,
   input  logic                    rd_en,
   input  logic                    rd_clr,
   input  logic [IDX_W-1:0]        rd_idx,
   output logic [DATA_WIDTH-1:0]   rd_data,
   input  logic                    wr_en,
   input  logic [DATA_WIDTH/8-1:0] wr_be,
   input  logic [IDX_W-1:0]        wr_idx,
   input  logic [DATA_WIDTH-1:0]   wr_data
);
   localparam int LANES = DATA_WIDTH / 8;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [7:0] bank [DEPTH_WORDS];
      logic [7:0] q;

      // rd_clr acts as the output register's synchronous reset
      always_ff @(posedge clk) begin
         if (wr_en && wr_be[l]) begin
            bank[wr_idx] <= wr_data[8*l +: 8];
         end
         if (rd_clr) begin
            q <= '0;
         end else if (rd_en) begin
            q <= bank[rd_idx];
         end
      end

      assign rd_data[8*l +: 8] = q;
   end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder: byte-masked writes, two-phase loads, PC stall generation
// Optional DMEM_BOUNDS_CHECK_EN: flags and suppresses accesses whose word index is >= DEPTH_WORDS.
module dmem_responder #(
   parameter int DATA_WIDTH  = dmem_responder_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH  = dmem_responder_pkg::RAM_ADDR_WIDTH,
   parameter int DEPTH_WORDS = dmem_responder_pkg::DMEM_DEPTH_WORDS
) (
   input  logic            clk,
   input  logic            rst,
   dmem_responder_if.slave bus
);
   import dmem_responder_pkg::*;

   localparam int IDX_W  = idx_width(DEPTH_WORDS);
   localparam int WORD_W = ADDR_WIDTH - 2;

   function automatic logic [IDX_W-1:0] word_idx(input logic [WORD_W-1:0] w);
      return IDX_W'(32'(w) % 32'(DEPTH_WORDS));
   endfunction

   dmem_state_e           state;
   logic [IDX_W-1:0]      cap_idx;
   logic [IDX_W-1:0]      w_idx;
   logic [DATA_WIDTH-1:0] rd_word;
   logic                  rd_en;
   logic                  rd_clr;
   logic                  wr_en;

   assign w_idx     = word_idx(bus.w_addr[ADDR_WIDTH-1:2]);
   assign rd_en     = (state == DMEM_ST_RD_WAIT);
   assign bus.r_dat = rd_word;

   // Combinational so the PC freezes in the very cycle the load is issued
   assign bus.stall = ((state == DMEM_ST_IDLE) && bus.r_enb && !rst) ||
                      (state == DMEM_ST_RD_WAIT);

`ifdef DMEM_BOUNDS_CHECK_EN
   function automatic logic out_of_range(input logic [WORD_W-1:0] w);
      return 32'(w) >= 32'(DEPTH_WORDS);
   endfunction

   logic w_oob;
   logic r_oob;
   logic cap_oob;

   assign w_oob  = out_of_range(bus.w_addr[ADDR_WIDTH-1:2]);
   assign r_oob  = out_of_range(bus.r_addr[ADDR_WIDTH-1:2]);
   assign wr_en  = bus.w_enb && !w_oob;
   assign rd_clr = rst || ((state == DMEM_ST_RD_WAIT) && cap_oob);

   always_ff @(posedge clk) begin
      if (rst) begin
         cap_oob        <= 1'b0;
         bus.access_err <= 1'b0;
      end else begin
         bus.access_err <= (bus.w_enb && w_oob) ||
                           ((state == DMEM_ST_IDLE) && bus.r_enb && r_oob);
         if ((state == DMEM_ST_IDLE) && bus.r_enb) begin
            cap_oob <= r_oob;
         end
      end
   end
`else
   assign wr_en  = bus.w_enb;
   assign rd_clr = rst;
`endif

   // RD_DONE always returns to IDLE so the same load's held r_enb cannot retrigger
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= DMEM_ST_IDLE;
         cap_idx     <= '0;
         bus.r_valid <= 1'b0;
      end else begin
         case (state)
            DMEM_ST_IDLE: begin
               bus.r_valid <= 1'b0;
               if (bus.r_enb) begin
                  cap_idx <= word_idx(bus.r_addr[ADDR_WIDTH-1:2]);
                  state   <= DMEM_ST_RD_WAIT;
               end
            end
            DMEM_ST_RD_WAIT: begin
               bus.r_valid <= 1'b1;
               state       <= DMEM_ST_RD_DONE;
            end
            DMEM_ST_RD_DONE: begin
               bus.r_valid <= 1'b0;
               state       <= DMEM_ST_IDLE;
            end
            default: begin
               bus.r_valid <= 1'b0;
               state       <= DMEM_ST_IDLE;
            end
         endcase
      end
   end

   dmem_array #(
      .DATA_WIDTH  (DATA_WIDTH),
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_array (
      .clk     (clk),
      .rd_en   (rd_en),
      .rd_clr  (rd_clr),
      .rd_idx  (cap_idx),
      .rd_data (rd_word),
      .wr_en   (wr_en),
      .wr_be   (bus.w_byte_enb),
      .wr_idx  (w_idx),
      .wr_data (bus.w_dat)
   );

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed and randomized checks of dmem_responder against a cycle-level memory model
// Define DMEM_BOUNDS_CHECK_EN to build with DEPTH_WORDS=16 and exercise access_err.
module tb_dmem_responder;

   localparam int AW = 12;
`ifdef DMEM_BOUNDS_CHECK_EN
   localparam int TB_DEPTH = 16;
   localparam int MAX_WORD = 31;
`else
   localparam int TB_DEPTH = 1024;
   localparam int MAX_WORD = 1023;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   dmem_responder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) dif ();

   dmem_responder #(
      .DATA_WIDTH  (32),
      .ADDR_WIDTH  (AW),
      .DEPTH_WORDS (TB_DEPTH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (dif)
   );

   int n_vec = 0;
   int n_err = 0;

   // Model: memory image plus the position within a load (0 idle, 1 second cycle, 2 third cycle)
   logic [31:0] ref_mem [TB_DEPTH];
   int          m_phase   = 0;
   int          m_cap     = 0;
   logic        m_cap_oob = 1'b0;
   logic [31:0] m_rdat    = '0;
   logic        m_err     = 1'b0;

   logic        obs_stall;
   logic        obs_valid;
   logic [31:0] obs_dat;
   logic        obs_err;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step(input logic rst_i, input logic we, input logic [AW-1:0] wa,
                       input logic [31:0] wd, input logic [3:0] wbe,
                       input logic re, input logic [AW-1:0] ra);
      int   widx;
      int   ridx;
      logic w_oob;
      logic r_oob;
      logic e_stall;
      @(negedge clk);
      rst            = rst_i;
      dif.w_enb      = we;
      dif.w_addr     = wa;
      dif.w_dat      = wd;
      dif.w_byte_enb = wbe;
      dif.r_enb      = re;
      dif.r_addr     = ra;
      #1;
      e_stall = ((m_phase == 0) && re && !rst_i) || (m_phase == 1);
      check_eq("stall",   32'(dif.stall),   32'(e_stall));
      check_eq("r_valid", 32'(dif.r_valid), 32'(m_phase == 2));
      check_eq("r_dat",   dif.r_dat,        m_rdat);
      obs_stall = dif.stall;
      obs_valid = dif.r_valid;
      obs_dat   = dif.r_dat;
`ifdef DMEM_BOUNDS_CHECK_EN
      check_eq("access_err", 32'(dif.access_err), 32'(m_err));
      obs_err = dif.access_err;
      widx  = int'(wa[AW-1:2]);
      ridx  = int'(ra[AW-1:2]);
      w_oob = (widx >= TB_DEPTH);
      r_oob = (ridx >= TB_DEPTH);
`else
      obs_err = 1'b0;
      widx  = int'(wa[AW-1:2]) % TB_DEPTH;
      ridx  = int'(ra[AW-1:2]) % TB_DEPTH;
      w_oob = 1'b0;
      r_oob = 1'b0;
`endif
      if (rst_i) begin
         m_phase = 0;
         m_rdat  = '0;
         m_err   = 1'b0;
      end else begin
         m_err = (we && w_oob) || ((m_phase == 0) && re && r_oob);
         case (m_phase)
            0: if (re) begin
               m_cap     = ridx % TB_DEPTH;
               m_cap_oob = r_oob;
               m_phase   = 1;
            end
            1: begin
               m_rdat  = m_cap_oob ? 32'h0 : ref_mem[m_cap];
               m_phase = 2;
            end
            default: m_phase = 0;
         endcase
         if (we && !w_oob) begin
            for (int l = 0; l < 4; l++) begin
               if (wbe[l]) ref_mem[widx][8*l +: 8] = wd[8*l +: 8];
            end
         end
      end
   endtask

   task automatic idle();
      step(1'b0, 1'b0, '0, '0, 4'h0, 1'b0, '0);
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
      step(1'b0, 1'b1, a, d, be, 1'b0, '0);
   endtask

   task automatic load_expect(input logic [AW-1:0] a, input logic [31:0] exp, input string tag);
      step(1'b0, 1'b0, '0, '0, 4'h0, 1'b1, a);
      check_eq({tag, "_stall_c1"}, 32'(obs_stall), 32'd1);
      step(1'b0, 1'b0, '0, '0, 4'h0, 1'b1, a);
      check_eq({tag, "_stall_c2"}, 32'(obs_stall), 32'd1);
      step(1'b0, 1'b0, '0, '0, 4'h0, 1'b1, a);
      check_eq({tag, "_stall_c3"}, 32'(obs_stall), 32'd0);
      check_eq({tag, "_valid_c3"}, 32'(obs_valid), 32'd1);
      check_eq({tag, "_data"},     obs_dat,        exp);
   endtask

   function automatic logic [AW-1:0] rand_addr();
      int w;
      w = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, MAXW_U())) : int'($urandom_range(0, 7));
      return {w[AW-3:0], 2'($urandom_range(0, 3))};
   endfunction

   function automatic int unsigned MAXW_U();
      return MAX_WORD;
   endfunction

   initial begin
      logic       pat [6];
      logic       re;
      logic       we;
      logic       rs;

      dif.w_enb      = 1'b0;
      dif.w_addr     = '0;
      dif.w_dat      = '0;
      dif.w_byte_enb = '0;
      dif.r_enb      = 1'b0;
      dif.r_addr     = '0;
      rst            = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         idle();
         check_eq("rst_idle_dat", obs_dat, 32'h0);
      end

      for (int i = 0; i < TB_DEPTH; i++) wr(AW'(i * 4), $urandom, 4'hF);

      wr(12'h010, 32'hDEADBEEF, 4'hF);
      wr(12'h010, 32'h00005500, 4'h2);
      load_expect(12'h010, 32'hDEAD55EF, "bytemask");
      wr(12'h010, 32'h12345678, 4'h0);
      load_expect(12'h010, 32'hDEAD55EF, "mask0_noop");

      wr(12'h020, 32'h11111111, 4'hF);
      wr(12'h024, 32'h22222222, 4'hF);
      pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 1'b0, '0, '0, 4'h0, 1'b1, (i < 3) ? 12'h020 : 12'h024);
         check_eq("b2b_stall", 32'(obs_stall), 32'(pat[i]));
         if (i == 2) check_eq("b2b_dat0", obs_dat, 32'h11111111);
         if (i == 5) check_eq("b2b_dat1", obs_dat, 32'h22222222);
      end
      idle();

      wr(12'h030, 32'hAAAAAAAA, 4'hF);
      step(1'b0, 1'b0, '0, '0, 4'h0, 1'b1, 12'h030);
      step(1'b0, 1'b1, 12'h030, 32'h55555555, 4'hF, 1'b1, 12'h030);
      step(1'b0, 1'b0, '0, '0, 4'h0, 1'b1, 12'h030);
      check_eq("rdfirst_old", obs_dat, 32'hAAAAAAAA);
      load_expect(12'h030, 32'h55555555, "rdfirst_new");

      wr(12'h034, 32'hCAFEF00D, 4'hF);
      step(1'b0, 1'b0, '0, '0, 4'h0, 1'b1, 12'h034);
      step(1'b1, 1'b0, '0, '0, 4'h0, 1'b1, 12'h034);
      step(1'b1, 1'b0, '0, '0, 4'h0, 1'b1, 12'h034);
      check_eq("midrst_stall", 32'(obs_stall), 32'd0);
      check_eq("midrst_valid", 32'(obs_valid), 32'd0);
      check_eq("midrst_dat",   obs_dat,        32'h0);
      idle();
      check_eq("midrst_novalid", 32'(obs_valid), 32'd0);
      load_expect(12'h034, 32'hCAFEF00D, "after_rst");

`ifdef DMEM_BOUNDS_CHECK_EN
      wr(12'h000, 32'h0BADF00D, 4'hF);
      wr(12'h040, 32'hFFFFFFFF, 4'hF);
      idle();
      check_eq("oob_wr_err", 32'(obs_err), 32'd1);
      idle();
      check_eq("oob_wr_err_clr", 32'(obs_err), 32'd0);
      load_expect(12'h000, 32'h0BADF00D, "oob_wr_kept");
      step(1'b0, 1'b0, '0, '0, 4'h0, 1'b1, 12'h044);
      step(1'b0, 1'b0, '0, '0, 4'h0, 1'b1, 12'h044);
      check_eq("oob_rd_err", 32'(obs_err), 32'd1);
      step(1'b0, 1'b0, '0, '0, 4'h0, 1'b1, 12'h044);
      check_eq("oob_rd_dat", obs_dat, 32'h0);
      check_eq("oob_rd_err_clr", 32'(obs_err), 32'd0);
`endif

      for (int i = 0; i < 3000; i++) begin
         rs = ($urandom_range(0, 99) == 0);
         we = !rs && ($urandom_range(0, 9) < 4);
         case (m_phase)
            1:       re = 1'b1;
            default: re = $urandom_range(0, 1) == 1;
         endcase
         step(rs, we, rand_addr(), $urandom, 4'($urandom_range(0, 15)), re, rand_addr());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the memory-side end of the core's data RAM port (d_w_*, d_r_*).
- Holds a byte-lane-writable word array.
- Performs single-cycle byte-masked writes and registered two-phase reads.
- Generates the stall that freezes the PC while load data is pending.
- Sits beside riscv_cpu in the top level. Its stall output feeds pc_stall, OR'd with any other stall sources.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be 32.
- ADDR_WIDTH, 12, byte-address width (matches RAM_ADDR_WIDTH).
- DEPTH_WORDS, 1024, number of words; 2^(ADDR_WIDTH-2) or less.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- w_addr  in  ADDR_WIDTH  word-aligned byte address for writes; bits [1:0] are ignored
- w_dat  in  32  write data, lane-positioned
- w_enb  in  1  write request
- w_byte_enb  in  4  byte-lane mask; bit i selects bits [8i+7:8i]
- r_addr  in  ADDR_WIDTH  byte address for reads; word index is r_addr[ADDR_WIDTH-1:2]
- r_enb  in  1  read request; held high by the core for the whole load
- r_dat  out  32  full read word (the core's byte_reader does lane selection)
- r_valid  out  1  r_dat is valid for the current load
- stall  out  1  freezes the PC and the core's write-back

Behaviour:
- States: IDLE, RD_WAIT, RD_DONE (encoded 2 bits).
- Reset: state=IDLE, r_dat=0, r_valid=0, stall=0, captured address=0. Array contents are not cleared.
- Reset mid-read: the next edge returns to IDLE and no r_valid pulse is issued.
- stall is combinational:
  - high when (state==IDLE && r_enb && !rst), or state==RD_WAIT;
  - low in RD_DONE.
- IDLE, r_enb=1: capture the word index of r_addr, go to RD_WAIT.
- RD_WAIT:
  - The array is read at the captured index; r_dat is registered at the end of this cycle.
  - Go to RD_DONE.
  - Later changes to r_addr are ignored.
- RD_DONE:
  - r_valid=1; r_dat holds the read word.
  - Go to IDLE unconditionally. This is the cycle in which the PC advances, so the same load's still-high r_enb must not retrigger a read.
- Back-to-back loads: IDLE sees r_enb again and starts a new read.
- Load-to-use cost: 2 stall cycles per load; the load completes on the 3rd cycle.
- r_dat holds its last value outside RD_DONE; r_valid is 0 outside RD_DONE.
- Writes:
  - Any state, w_enb=1: at the clock edge, lane i of word w_addr[ADDR_WIDTH-1:2] := w_dat lane i for each set w_byte_enb[i].
  - No stall and no latency visible to the core.
  - w_byte_enb=0000 with w_enb=1 is a no-op.
- Write and read hitting the same word in the same cycle: read-first; the read returns pre-write contents.
- A write landing in RD_WAIT on the captured word: also read-first (old data returned).
- Addresses with word index >= DEPTH_WORDS wrap modulo DEPTH_WORDS.
- Integration requirement: the core gates register write-back with r_valid, or with !stall.

Optional Feature:
- Macro: DMEM_BOUNDS_CHECK_EN.
- When defined:
  - Extra output port access_err (1 bit, reset 0).
  - Set for one cycle on the edge after any w_enb or (IDLE && r_enb) whose word index >= DEPTH_WORDS.
  - Faulting writes are suppressed.
  - Faulting reads complete with r_dat=32'h0000_0000.
- When undefined: the port is absent, and out-of-range addresses wrap as above.

Decomposition:
- In rv32i_params.vh:
  - DMEM_ST_IDLE=2'd0, DMEM_ST_RD_WAIT=2'd1, DMEM_ST_RD_DONE=2'd2;
  - DMEM_DEPTH_WORDS default.
- Reuse the existing DATA_WIDTH and RAM_ADDR_WIDTH.
- One sub-module: dmem_array. It holds four byte-wide banks (BRAM-inferable) with a synchronous read port and a byte-enabled write port; the FSM lives in dmem_responder.

Test Plan:
- Reset then idle: after rst held 2 cycles, r_dat=0, r_valid=0, stall=0; with r_enb=0 these stay 0 for 10 cycles.
- Byte-masked write then load:
  - Write 0xDEADBEEF to addr 0x010 with mask 1111, then write 0x00005500 with mask 0010.
  - Load at 0x010: stall high for 2 cycles, 3rd cycle r_valid=1 and r_dat=0xDEAD55EF.
- Back-to-back loads: word 0x020=0x11111111, word 0x024=0x22222222; r_enb held across both loads, r_addr switched at PC advance → stall pattern 1,1,0,1,1,0 and data 0x11111111 then 0x22222222.
- Read-first collision:
  - Word 0x030=0xAAAAAAAA; start a load at 0x030 and write 0x55555555 there during RD_WAIT.
  - Load returns 0xAAAAAAAA; the next load returns 0x55555555.
- Reset mid-read: assert rst in RD_WAIT → next cycle state=IDLE, stall=0, r_valid never pulses; a subsequent load still returns the correct data.
- DMEM_BOUNDS_CHECK_EN, DEPTH_WORDS=16:
  - Write to 0x040 → access_err pulses 1 cycle and word 0 is unchanged.
  - Read from 0x044 → r_dat=0, access_err pulses.
